uart_word_loader: RTL and testbench
===================================

# uart_word_loader

Receive-side counterpart of the register-dump transmit FIFO on the pipeline debug link. Takes bytes from the UART receiver and packs them LSB-first into 32-bit words, using the same byte order the transmit side uses to send a 32-bit register. Writes each completed word to the instruction memory at incrementing word addresses. Sits between the UART RX core and the instruction-memory write port, and holds the pipeline out of run until the load finishes.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of the instruction-memory word address; must be ≥ 8.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from UART RX; valid only while rx_done_tick=1
- rx_done_tick  in  1  one-cycle strobe, one new byte per strobe
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word
- mem_addr  out  ADDR_WIDTH  word address of the current write
- mem_wdata  out  32  packed word
- busy  out  1  high from count-byte acceptance until load_done
- load_done  out  1  sticky high once all words are written; cleared only by reset
- words_loaded  out  8  number of words written so far

## Operation
- Protocol: byte 0 is the word count N (0..255). It is followed by 4·N data bytes, least-significant byte first.
- FSM states: IDLE, RECV, WRITE, DONE.
  - IDLE: waits for a tick.
    - Tick with N=0 → DONE.
    - Tick with N>0 → RECV, with remaining=N, byte_idx=0, addr=0.
  - RECV: each tick stores rx_data into word bits [8·byte_idx+7 : 8·byte_idx], then byte_idx increments.
    - The tick that fills byte_idx=3 → WRITE.
  - WRITE: exactly one cycle, with mem_we=1, mem_addr=addr and mem_wdata=the packed word. At the end of the cycle: addr+1, remaining−1, words_loaded+1, byte_idx=0.
    - remaining becomes 0 → DONE.
    - Otherwise → RECV.
  - DONE: load_done=1, busy=0. All further ticks are ignored until reset.
- A tick arriving during WRITE is not lost when more words remain: it is stored as byte 0 of the next word, and the FSM enters RECV with byte_idx=1. If WRITE is the last word, the tick is ignored.
- The word register is not cleared between words; every byte lane is overwritten before it is used.
- Addresses are zero-extended to ADDR_WIDTH. No wrap occurs, because N ≤ 255 and ADDR_WIDTH ≥ 8.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, load_done=0, words_loaded=0. State=IDLE, byte_idx=0, remaining=0.
- Reset asserted in any state forces all of the above on the next edge. A partially assembled word is discarded and the host must resend from the count byte.
- Latency: mem_we is high in the cycle immediately after the edge that sampled the 4th byte's tick.
- busy rises in the cycle after the count-byte tick.
- load_done rises in the cycle after the last WRITE cycle. For N=0 it rises in the cycle after the count tick.
- mem_addr and mem_wdata are registered and stable for the whole mem_we cycle. mem_we is never high for two consecutive cycles.
- rx_data is sampled only on cycles where rx_done_tick=1.

## Structure
- Shared package `debug_link_pkg` holds:
  - the state encoding constants (IDLE=2'b00, RECV=2'b01, WRITE=2'b10, DONE=2'b11);
  - BYTES_PER_WORD=4;
  - the byte-order convention (LSB first), shared with the transmit FIFO.
- One natural sub-module, `word_packer`: a 4-lane byte register with a lane-select write, and byte_idx reset/clear controls. The FSM, counters and memory port live in the top module.

## Test plan
- Count byte 0x00 → no mem_we; load_done=1 and busy=0 one cycle after the tick; words_loaded=0.
- N=1, bytes AF,D7,EB,05 → single mem_we with mem_addr=0 and mem_wdata=0x05EBD7AF; load_done the next cycle; words_loaded=1.
- N=3 with words 0x00000001, 0xDEADBEEF, 0xFFFFFFFF → mem_we at addrs 0, 1, 2 with those data values; words_loaded=3.
- N=2, with the first tick of word 2 placed exactly in the WRITE cycle of word 1 → word 2 assembles correctly and is written at addr 1.
- N=2, reset pulsed after 6 data bytes → all outputs return to reset values. A resent N=1, 11,22,33,44 then writes 0x44332211 at addr 0.
- After load_done, 8 further ticks → no mem_we; outputs unchanged.

Source files
------------

// File: rtl/debug_link_pkg.sv
// Shared definitions for the pipeline debug link: FSM encoding and the
// byte order used by both the transmit FIFO and the receive-side loader.
package debug_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RECV  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  // Byte 0 on the wire is the least-significant byte of a word.
  localparam bit LSB_FIRST = 1'b1;

  function automatic int laneLsb(input logic [BYTE_IDX_W-1:0] idx);
    return LSB_FIRST ? 8 * int'(idx) : 8 * (BYTES_PER_WORD - 1 - int'(idx));
  endfunction

endpackage

// File: rtl/uart_word_loader_word_packer.sv
// Four-lane byte register that assembles a 32-bit word one byte at a time.
// A clear coinciding with a write stores into lane 0 and leaves the index at 1.
module word_packer
  import debug_link_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic                  idx_clear_i,
  input  logic [7:0]            byte_i,
  output logic [31:0]           word_o,
  output logic [BYTE_IDX_W-1:0] byte_idx_o
);

  logic [31:0]           word_q;
  logic [BYTE_IDX_W-1:0] idx_q;
  logic [BYTE_IDX_W-1:0] wrIdx;

  always_comb begin
    wrIdx = idx_clear_i ? '0 : idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (wr_en_i) begin
      word_q[laneLsb(wrIdx) +: 8] <= byte_i;
      idx_q <= wrIdx + BYTE_IDX_W'(1);
    end else if (idx_clear_i) begin
      idx_q <= '0;
    end
  end

  assign word_o     = word_q;
  assign byte_idx_o = idx_q;

endmodule

// File: rtl/uart_word_loader.sv
// Loads a count-prefixed stream of UART bytes into instruction memory as
// LSB-first 32-bit words, holding the pipeline out of run until complete.
module uart_word_loader
  import debug_link_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done_tick,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  load_done,
  output logic [7:0]            words_loaded
);

  state_e                  state_q;
  logic [7:0]              remaining_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              words_q;
  logic                    we_q;
  logic                    busy_q;
  logic                    done_q;

  logic                  lastWord;
  logic                  packWe;
  logic                  packClear;
  logic                  wordFull;
  logic [31:0]           packedWord;
  logic [BYTE_IDX_W-1:0] byteIdx;

  // A tick during WRITE starts the next word unless this was the final one.
  always_comb begin
    lastWord  = (remaining_q == 8'd1);
    packWe    = rx_done_tick && ((state_q == RECV) || ((state_q == WRITE) && !lastWord));
    packClear = (state_q == IDLE) || (state_q == WRITE);
    wordFull  = rx_done_tick && (state_q == RECV) && (byteIdx == LAST_BYTE_IDX);
  end

  word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (packWe),
    .idx_clear_i (packClear),
    .byte_i      (rx_data),
    .word_o      (packedWord),
    .byte_idx_o  (byteIdx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      words_q     <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_done_tick) begin
            if (rx_data == 8'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= RECV;
              remaining_q <= rx_data;
              addr_q      <= '0;
              busy_q      <= 1'b1;
            end
          end
        end
        RECV: begin
          if (wordFull) begin
            state_q <= WRITE;
            we_q    <= 1'b1;
          end
        end
        WRITE: begin
          addr_q      <= addr_q + ADDR_WIDTH'(1);
          remaining_q <= remaining_q - 8'd1;
          words_q     <= words_q + 8'd1;
          if (lastWord) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= RECV;
          end
        end
        DONE: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = packedWord;
  assign busy         = busy_q;
  assign load_done    = done_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Scoreboard bench: stimulus pushes expected memory writes, a negedge monitor
// pops and compares them whenever the loader pulses mem_we.
module tb_uart_word_loader;

  localparam int AW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_done_tick;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          load_done;
  logic [7:0]    words_loaded;

  wr_t         expQ[$];
  logic [31:0] loadWords[$];
  int          errors = 0;
  int          checks = 0;
  logic        prevWe = 1'b0;

  always #5 clk = ~clk;

  uart_word_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .load_done    (load_done),
    .words_loaded (words_loaded)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Every write the loader makes must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checkOutput("weNotBackToBack", {31'd0, prevWe}, 32'd0);
      checkOutput("writeExpected", {31'd0, expQ.size() != 0}, 32'd1);
      if (expQ.size() != 0) begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("memAddr", 32'(mem_addr), 32'(e.addr));
        checkOutput("memWdata", mem_wdata, e.data);
      end
    end
    prevWe = (mem_we === 1'b1);
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    rx_data      = 8'($urandom);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_we"},    {31'd0, mem_we}, 32'd0);
    checkOutput({tag, "_addr"},  32'(mem_addr), 32'd0);
    checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_busy"},  {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"},  {31'd0, load_done}, 32'd0);
    checkOutput({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    idleCycles(1);
    reset = 1'b0;
  endtask

  // Sends count + loadWords, expecting word i at address i, LSB byte first.
  task automatic runLoad(input int maxGap);
    int          n;
    logic [31:0] w;
    wr_t         e;
    n = loadWords.size();
    applyStimulus(n[7:0]);
    checkOutput("busyAfterCount", {31'd0, busy}, {31'd0, n != 0});
    if (n == 0) begin
      checkOutput("doneAfterZero", {31'd0, load_done}, 32'd1);
    end
    for (int i = 0; i < n; i++) begin
      w = loadWords[i];
      for (int k = 0; k < 4; k++) begin
        idleCycles($urandom_range(maxGap, 0));
        if (k == 3) begin
          e.addr = AW'(i);
          e.data = w;
          expQ.push_back(e);
        end
        applyStimulus(8'((w >> (8 * k)) & 32'hFF));
      end
    end
    if (n != 0) begin
      checkOutput("doneLowInLastWrite", {31'd0, load_done}, 32'd0);
      idleCycles(1);
      checkOutput("doneAfterLoad", {31'd0, load_done}, 32'd1);
    end
    checkOutput("busyAfterLoad", {31'd0, busy}, 32'd0);
    checkOutput("wordsLoaded", 32'(words_loaded), 32'(n));
    checkOutput("pendingWrites", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] snapAddr;
    logic [31:0]   snapData;
    logic [7:0]    snapWords;
    int            n;
    wr_t           e;

    reset        = 1'b1;
    rx_data      = 8'd0;
    rx_done_tick = 1'b0;
    idleCycles(2);
    reset = 1'b0;
    checkResetState("reset");

    // Empty load
    loadWords = {};
    runLoad(0);

    // Single word, then ticks after completion must be ignored
    resetDut();
    loadWords = {};
    loadWords.push_back(32'h05EBD7AF);
    runLoad(2);
    snapAddr  = mem_addr;
    snapData  = mem_wdata;
    snapWords = words_loaded;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'($urandom));
      idleCycles($urandom_range(1, 0));
    end
    checkOutput("postDoneAddr",  32'(mem_addr), 32'(snapAddr));
    checkOutput("postDoneWdata", mem_wdata, snapData);
    checkOutput("postDoneWords", 32'(words_loaded), 32'(snapWords));
    checkOutput("postDoneFlag",  {31'd0, load_done}, 32'd1);
    checkOutput("postDoneBusy",  {31'd0, busy}, 32'd0);

    // Three words
    resetDut();
    loadWords = {};
    loadWords.push_back(32'h00000001);
    loadWords.push_back(32'hDEADBEEF);
    loadWords.push_back(32'hFFFFFFFF);
    runLoad(1);

    // Back-to-back bytes put the first tick of word 2 in the WRITE cycle
    resetDut();
    loadWords = {};
    loadWords.push_back(32'hCAFEF00D);
    loadWords.push_back(32'h12345678);
    runLoad(0);

    // Reset in the middle of the second word discards it
    resetDut();
    applyStimulus(8'd2);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        e.addr = '0;
        e.data = 32'h04030201;
        expQ.push_back(e);
      end
      applyStimulus(8'(k + 1));
    end
    checkOutput("midLoadBusy", {31'd0, busy}, 32'd1);
    resetDut();
    checkResetState("midReset");
    checkOutput("midResetPending", 32'(expQ.size()), 32'd0);
    loadWords = {};
    loadWords.push_back(32'h44332211);
    runLoad(0);

    // Random loads with random byte spacing
    for (int r = 0; r < 6; r++) begin
      resetDut();
      n = $urandom_range(8, 1);
      loadWords = {};
      for (int i = 0; i < n; i++) begin
        loadWords.push_back($urandom);
      end
      runLoad(3);
    end

    idleCycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
